// File: rtl/apb_ep_pkg.sv
// Shared register offsets, bit positions and APB FSM state type for the APB RX endpoint.
package apb_ep_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_KEY    = 4'hC;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_ep_state_t;

endpackage

// File: rtl/apb_ep_fifo.sv
// Synchronous FIFO: push lands next cycle, head is always mem[rd_ptr]; push ignored when full,
// pop ignored when empty, flush overrides both.
module apb_ep_fifo
  import apb_ep_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_vld,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head_dat
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_vld && !full;
    do_pop   = pop_vld && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are PTR_W wide, so a power-of-2 depth wraps for free.
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/apb_rx_endpoint.sv
// APB3 slave feeding a FIFO drained on a valid/ready stream; pready after WAIT_CYCLES access cycles,
// full FIFO rejects DATA writes with pslverr. Optional KEY/XOR decrypt under APB_EP_DECRYPT_EN.
module apb_rx_endpoint
  import apb_ep_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);

  localparam int         CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  apb_ep_state_t     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              ovf_q, ovf_d;
  logic              pready_w;
  logic              push_vld;
  logic              flush;
  logic              pop_vld;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] rd_dat;
  logic [DATA_W-1:0] status_dat;
  logic [3:0]        off;
  logic              err;
  logic              unused_addr;

`ifdef APB_EP_DECRYPT_EN
  logic [DATA_W-1:0] key_q, key_d;
`endif

  assign off         = paddr[3:0];
  assign unused_addr = ^paddr[ADDR_W-1:4];

  // Reset gating keeps a transfer caught by reset from completing in that cycle.
  assign pready_w = (state_q == ACCESS) && psel && penable && (cnt_q == WAIT_C) && !rst;
  assign pready   = pready_w;
  assign prdata   = rd_dat;
  assign pslverr  = err;

  assign m_valid = en_q && !fifo_empty;
  assign pop_vld = m_valid && m_ready;

`ifdef APB_EP_DECRYPT_EN
  assign m_data = fifo_head ^ key_q;
`else
  assign m_data = fifo_head;
`endif

  always_comb begin
    status_dat                           = '0;
    status_dat[ST_EMPTY]                 = fifo_empty;
    status_dat[ST_FULL]                  = fifo_full;
    status_dat[ST_OVF]                   = ovf_q;
    status_dat[ST_CNT_LSB +: CNT_W]      = fifo_count;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:    if (psel && !penable) state_d = ACCESS;
      ACCESS:  if (pready_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!psel) begin
      state_d = IDLE;
    end
    if ((state_q == ACCESS) && psel && penable && !pready_w) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    rd_dat   = '0;
    err      = 1'b0;
    push_vld = 1'b0;
    flush    = 1'b0;
    en_d     = en_q;
    ovf_d    = ovf_q;
`ifdef APB_EP_DECRYPT_EN
    key_d    = key_q;
`endif
    if (pready_w) begin
      if (off[1:0] != 2'b00) begin
        err = 1'b1;
      end else begin
        case (off)
          REG_DATA: begin
            if (pwrite) begin
              // Fullness is judged on the registered count, so a same-cycle pop does not save the word.
              if (fifo_full) begin
                err   = 1'b1;
                ovf_d = 1'b1;
              end else begin
                push_vld = 1'b1;
              end
            end
          end
          REG_STATUS: begin
            if (pwrite) err = 1'b1;
            else        rd_dat = status_dat;
          end
          REG_CTRL: begin
            if (pwrite) begin
              en_d  = pwdata[CTRL_EN];
              flush = pwdata[CTRL_FLUSH];
            end else begin
              rd_dat[CTRL_EN] = en_q;
            end
          end
`ifdef APB_EP_DECRYPT_EN
          REG_KEY: begin
            if (pwrite) key_d  = pwdata;
            else        rd_dat = key_q;
          end
`endif
          default: err = 1'b1;
        endcase
      end
    end
    if (flush) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef APB_EP_DECRYPT_EN
      key_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
`ifdef APB_EP_DECRYPT_EN
      key_q   <= key_d;
`endif
    end
  end

  apb_ep_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (pwdata),
    .pop_vld  (pop_vld),
    .flush    (flush),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head_dat (fifo_head)
  );

endmodule

// File: tb/tb_apb_rx_endpoint.sv
// Directed bench: dut (0 wait states) covers registers, FIFO and stream; dut_w (3 wait states) covers timing.
module tb_apb_rx_endpoint;

`ifdef APB_EP_DECRYPT_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        m_ready;
  int          tgt;

  logic [31:0] prdata0, prdata1, m_data0, m_data1;
  logic        pready0, pready1, pslverr0, pslverr1, m_valid0, m_valid1;

  logic        cur_pready, cur_pslverr;
  logic [31:0] cur_prdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_rx_endpoint #(.FIFO_DEPTH(8), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .psel(psel && tgt == 0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .m_valid(m_valid0), .m_data(m_data0), .m_ready(m_ready)
  );

  apb_rx_endpoint #(.FIFO_DEPTH(8), .WAIT_CYCLES(3)) dut_w (
    .clk(clk), .rst(rst), .psel(psel && tgt == 1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
    .m_valid(m_valid1), .m_data(m_data1), .m_ready(1'b0)
  );

  assign cur_pready  = (tgt == 1) ? pready1  : pready0;
  assign cur_pslverr = (tgt == 1) ? pslverr1 : pslverr0;
  assign cur_prdata  = (tgt == 1) ? prdata1  : prdata0;

  logic        cap;
  logic [31:0] popped[$];
  always @(negedge clk) begin
    if (cap && m_valid0 && m_ready) popped.push_back(m_data0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One full APB transfer; rdy_acc raises m_ready only for the access phase.
  task automatic apb(input int t, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic rdy_acc, output logic [31:0] rd, output logic er, output int waits);
    bit done = 0;
    bit leak = 0;
    waits = 0;
    rd    = '0;
    er    = 1'b0;
    @(posedge clk); #1;
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    if (rdy_acc) m_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (cur_pready) begin
        rd = cur_prdata; er = cur_pslverr; done = 1;
      end else begin
        waits++;
        if (cur_prdata !== 32'h0 || cur_pslverr !== 1'b0) leak = 1;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    if (rdy_acc) m_ready = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL apb_timeout: got no pready expected pready within 40 cycles addr=0x%08h", a);
    end
    if (leak) begin
      n_chk++; n_fail++;
      $display("FAIL prdata_early: got nonzero prdata/pslverr expected 0 before pready");
    end
  endtask

  task automatic wr_chk(input string nm, input logic [31:0] a, input logic [31:0] d, input logic exp_err);
    logic [31:0] rd; logic er; int w;
    apb(0, 1'b1, a, d, 1'b0, rd, er, w);
    chk(nm, {31'b0, er}, {31'b0, exp_err});
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic er; int w;
    apb(0, 1'b0, a, 32'h0, 1'b0, rd, er, w);
    chk(nm, rd, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    m_ready = 1'b0; tgt = 0; cap = 1'b0;

    vecs[0] = '{1'b1, 32'h0, 32'hA5A5_0001, 32'h0,      1'b0};
    vecs[1] = '{1'b0, 32'h4, 32'h0,         32'h0100,   1'b0};
    vecs[2] = '{1'b0, 32'h0, 32'h0,         32'h0,      1'b0};
    vecs[3] = '{1'b1, 32'h4, 32'hFFFF,      32'h0,      1'b1};
    vecs[4] = '{1'b0, 32'h2, 32'h0,         32'h0,      1'b1};
    vecs[5] = '{1'b1, 32'h9, 32'h77,        32'h0,      1'b1};
    vecs[6] = '{1'b0, 32'hC, 32'h0,         32'h0,      !DEC};
    vecs[7] = '{1'b0, 32'h8, 32'h0,         32'h0,      1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready",  {31'b0, pready0},  32'h0);
    chk("rst_prdata",  prdata0,           32'h0);
    chk("rst_pslverr", {31'b0, pslverr0}, 32'h0);
    chk("rst_m_valid", {31'b0, m_valid0}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("rst_status", 32'h4, 32'h0001);

    for (int i = 0; i < 8; i++) begin
      apb(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, w);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      if (i == 0) chk("first_write_waits", w, 0);
    end

    // Fill to 8 (the misaligned write must not have pushed), then overflow.
    for (int i = 2; i <= 8; i++) wr_chk($sformatf("fill%0d_err", i), 32'h0, i, 1'b0);
    rd_chk("status_full", 32'h4, 32'h0802);
    wr_chk("ninth_write_err", 32'h0, 32'h9, 1'b1);
    rd_chk("status_ovf", 32'h4, 32'h0806);

    m_ready = 1'b1;
    wr_chk("flush_en_err", 32'h8, 32'h3, 1'b0);
    @(negedge clk);
    chk("flush_m_valid", {31'b0, m_valid0}, 32'h0);
    rd_chk("flush_status", 32'h4, 32'h0001);
    rd_chk("ctrl_readback", 32'h8, 32'h0001);
    m_ready = 1'b0;

    // en=1, no consumer: head must be the first word and hold steady.
    for (int i = 0; i < 8; i++) wr_chk("fill_en_err", 32'h0, 32'h100 + i, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("head_m_valid", {31'b0, m_valid0}, 32'h1);
    chk("head_stable",  m_data0, 32'h100);
    apb(0, 1'b1, 32'h0, 32'hDEAD, 1'b1, rd, er, w);
    chk("full_pop_same_cycle_err", {31'b0, er}, 32'h1);
    rd_chk("status_after_pop_full", 32'h4, 32'h0704);
    @(negedge clk);
    chk("head_after_pop", m_data0, 32'h101);
    apb(0, 1'b1, 32'h8, 32'h3, 1'b1, rd, er, w);
    @(negedge clk);
    chk("flush_vs_pop_m_valid", {31'b0, m_valid0}, 32'h0);
    rd_chk("flush_vs_pop_status", 32'h4, 32'h0001);

    m_ready = 1'b1;
    cap = 1'b1;
    for (int i = 1; i <= 4; i++) wr_chk("stream_push_err", 32'h0, i, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    cap = 1'b0;
    chk("stream_count", popped.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < popped.size()) chk($sformatf("stream_word%0d", i), popped[i], i + 1);
    end
    chk("stream_drained_valid", {31'b0, m_valid0}, 32'h0);
    rd_chk("stream_drained_status", 32'h4, 32'h0001);
    m_ready = 1'b0;

`ifdef APB_EP_DECRYPT_EN
    wr_chk("ctrl_off_err", 32'h8, 32'h0, 1'b0);
    wr_chk("key_write_err", 32'hC, 32'hFFFF_0000, 1'b0);
    rd_chk("key_readback", 32'hC, 32'hFFFF_0000);
    wr_chk("dec_push_err", 32'h0, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("decrypt_m_data", m_data0, 32'hEDCB_5678);
    wr_chk("dec_flush_err", 32'h8, 32'h2, 1'b0);
`endif

    apb(1, 1'b0, 32'h4, 32'h0, 1'b0, rd, er, w);
    chk("wait3_read_waits", w, 3);
    chk("wait3_read_data", rd, 32'h0001);
    chk("wait3_read_err", {31'b0, er}, 32'h0);
    apb(1, 1'b1, 32'h0, 32'hCAFE, 1'b0, rd, er, w);
    chk("wait3_write_waits", w, 3);
    apb(1, 1'b0, 32'h4, 32'h0, 1'b0, rd, er, w);
    chk("wait3_status", rd, 32'h0100);

    // Reset lands in what would otherwise be the completing access cycle.
    wr_chk("pre_rst_push_err", 32'h0, 32'h55, 1'b0);
    @(posedge clk); #1;
    tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h66;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pready", {31'b0, pready0}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    rd_chk("rst_mid_status", 32'h4, 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
